fetch_unit: RTL

//  Instruction fetch stage sitting between the PC register and the decoder.

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: PC register, instruction-memory and decode signals.
// master = fetch_unit side, slave = surrounding pipeline / memory side.
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_write;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_fault;

    modport master (
        input  pc_in, stall, branch_taken, branch_target,
               mem_rd_ack, mem_rd_data, instr_ready,
        output pc_next, pc_write, mem_addr, mem_rd_req,
               instr_out, instr_pc, instr_valid, fetch_fault
    );

    modport slave (
        output pc_in, stall, branch_taken, branch_target,
               mem_rd_ack, mem_rd_data, instr_ready,
        input  pc_next, pc_write, mem_addr, mem_rd_req,
               instr_out, instr_pc, instr_valid, fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC -> memory read (req/ack) -> decode (valid/ready).
// Optional misaligned-PC fault enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                INSTR_BYTES = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = 'h400
) (
    input logic          clk,
    input logic          clear,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              pc_write_q, pc_write_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] pc_cur;
    logic              misaligned;

    // pc_in only reflects a pc_write one edge later, so forward the value being loaded
    assign pc_cur = pc_write_q ? pc_next_q : bus.pc_in;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_cur % ADDR_W'(INSTR_BYTES)) != '0;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        pc_next_d  = pc_next_q;
        pc_write_d = 1'b0;
        req_d      = req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;

        if (bus.branch_taken) begin
            pc_next_d  = bus.branch_target;
            pc_write_d = 1'b1;
            valid_d    = 1'b0;
            req_d      = 1'b0;
            fault_d    = 1'b0;
            state_d    = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!bus.stall && !fault_q) begin
                        if (misaligned) begin
                            fault_d = 1'b1;
                        end else begin
                            state_d    = S_REQ;
                            req_d      = 1'b1;
                            mem_addr_d = pc_cur;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_rd_ack) begin
                        instr_d    = bus.mem_rd_data;
                        instr_pc_d = mem_addr_q;
                        valid_d    = 1'b1;
                        pc_next_d  = mem_addr_q + ADDR_W'(INSTR_BYTES);
                        pc_write_d = 1'b1;
                        req_d      = 1'b0;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (valid_q && bus.instr_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                        if (!bus.stall) begin
                            if (misaligned) begin
                                fault_d = 1'b1;
                            end else begin
                                state_d    = S_REQ;
                                req_d      = 1'b1;
                                mem_addr_d = pc_cur;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= S_IDLE;
            pc_next_q  <= RESET_ADDR;
            pc_write_q <= 1'b0;
            req_q      <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_d;
            pc_next_q  <= pc_next_d;
            pc_write_q <= pc_write_d;
            req_q      <= req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.pc_next     = pc_next_q;
    assign bus.pc_write    = pc_write_q;
    assign bus.mem_rd_req  = req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_fault = fault_q;
endmodule
